sha3_sponge_kem: RTL



---
 rtl/sha3_sponge_kem.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/sha3_sponge_kem.sv
// Keccak sponge controller covering the ML-KEM hash and XOF modes:
// SHA3-256 (H), SHA3-512 (G), SHAKE128 (XOF) and SHAKE256 (J/PRF).
// It absorbs a byte stream into the rate and applies FIPS 202 padding.
// It hands the state to an external Keccak-f[1600] core and streams out
// the digest or the XOF bytes.
module sha3_sponge_kem #(
  parameter int DIN_W  = 64,
  parameter int DOUT_W = 64,
  parameter int LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [LEN_W-1:0]  msg_len_i,
  input  logic [LEN_W-1:0]  out_len_i,
  input  logic              din_valid_i,
  output logic              din_ready_o,
  input  logic [DIN_W-1:0]  din_i,
  output logic              dout_valid_o,
  input  logic              dout_ready_i,
  output logic [DOUT_W-1:0] dout_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              perm_run_o,
  output logic [1599:0]     perm_state_o,
  input  logic              perm_done_i,
  input  logic [1599:0]     perm_state_i
);

  localparam int DIN_B  = DIN_W / 8;
  localparam int DOUT_B = DOUT_W / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABSORB,
    S_PAD,
    S_PERM,
    S_SQUEEZE,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  state_e           ret_q, ret_d;
  logic [1599:0]    s_q, s_d;
  logic [7:0]       off_q, off_d;
  logic [LEN_W-1:0] msg_rem_q, msg_rem_d;
  logic [LEN_W-1:0] out_rem_q, out_rem_d;
  logic [1:0]       mode_q, mode_d;
  logic             perm_run_q, perm_run_d;

  logic [7:0]       rate;
  logic [7:0]       dom_byte;
  logic [LEN_W-1:0] din_take;
  logic [LEN_W-1:0] dout_take;

  // Bit position of a state byte; the rate never exceeds 168 bytes, so
  // offset plus beat size always stays inside the 200-byte state.
  function automatic logic [10:0] bit_pos(input logic [7:0] byte_idx);
    return {byte_idx, 3'b000};
  endfunction

  // Decode the rate and domain byte from the latched mode.
  // Also work out how many bytes the current beat really carries.
  always_comb begin
    case (mode_q)
      2'd1:    rate = 8'd72;
      2'd2:    rate = 8'd168;
      default: rate = 8'd136;
    endcase
    dom_byte  = mode_q[1] ? 8'h1F : 8'h06;
    din_take  = (msg_rem_q < LEN_W'(DIN_B))  ? msg_rem_q : LEN_W'(DIN_B);
    dout_take = (out_rem_q < LEN_W'(DOUT_B)) ? out_rem_q : LEN_W'(DOUT_B);
  end

  // Next-state logic for the sponge FSM and its datapath registers.
  always_comb begin
    // NOTE: every variable gets a default before the case statement, and
    // all assignments here are blocking. This keeps the block purely
    // combinational, so no latch is inferred. It also lets later byte
    // updates see the earlier ones, which matters when the domain byte and
    // the 0x80 byte fall on the same byte.
    state_d   = state_q;
    ret_d     = ret_q;
    s_d       = s_q;
    off_d     = off_q;
    msg_rem_d = msg_rem_q;
    out_rem_d = out_rem_q;
    mode_d    = mode_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d    = mode_i;
          msg_rem_d = msg_len_i;
          case (mode_i)
            2'd0:    out_rem_d = LEN_W'(32);
            2'd1:    out_rem_d = LEN_W'(64);
            default: out_rem_d = out_len_i;
          endcase
          s_d     = '0;
          off_d   = '0;
          state_d = (msg_len_i == '0) ? S_PAD : S_ABSORB;
        end
      end

      S_ABSORB: begin
        if (din_valid_i) begin
          for (int k = 0; k < DIN_B; k++) begin
            if (LEN_W'(k) < msg_rem_q) begin
              s_d[bit_pos(off_q + 8'(k)) +: 8] =
                s_q[bit_pos(off_q + 8'(k)) +: 8] ^ din_i[8*k +: 8];
            end
          end
          off_d     = off_q + 8'(din_take);
          msg_rem_d = msg_rem_q - din_take;
          if (off_d == rate) begin
            state_d = S_PERM;
            ret_d   = (msg_rem_d == '0) ? S_PAD : S_ABSORB;
          end else if (msg_rem_d == '0) begin
            state_d = S_PAD;
          end
        end
      end

      S_PAD: begin
        s_d[bit_pos(off_q) +: 8] = s_q[bit_pos(off_q) +: 8] ^ dom_byte;
        s_d[bit_pos(rate - 8'd1) +: 8] = s_d[bit_pos(rate - 8'd1) +: 8] ^ 8'h80;
        state_d = S_PERM;
        ret_d   = S_SQUEEZE;
      end

      S_PERM: begin
        if (perm_done_i) begin
          s_d   = perm_state_i;
          off_d = '0;
          if (ret_q == S_SQUEEZE && out_rem_q == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = ret_q;
          end
        end
      end

      S_SQUEEZE: begin
        if (dout_ready_i) begin
          off_d     = off_q + 8'(DOUT_B);
          out_rem_d = out_rem_q - dout_take;
          if (out_rem_d == '0) begin
            state_d = S_DONE;
          end else if (off_d == rate) begin
            state_d = S_PERM;
            ret_d   = S_SQUEEZE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    perm_run_d = (state_d == S_PERM) && (state_q != S_PERM);
  end

  // Register all state; the reset is synchronous and active-low.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      ret_q      <= S_IDLE;
      // NOTE: the 1600-bit state is a flop array, not a RAM. It is cleared
      // on reset so that perm_state_o never shows a previous secret after
      // a reset.
      s_q        <= '0;
      off_q      <= '0;
      msg_rem_q  <= '0;
      out_rem_q  <= '0;
      mode_q     <= '0;
      perm_run_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      s_q        <= s_d;
      off_q      <= off_d;
      msg_rem_q  <= msg_rem_d;
      out_rem_q  <= out_rem_d;
      mode_q     <= mode_d;
      perm_run_q <= perm_run_d;
    end
  end

  // Output beat: state bytes at the squeeze offset.
  // Bytes past the requested output length are zeroed.
  always_comb begin
    dout_o = '0;
    for (int k = 0; k < DOUT_B; k++) begin
      if (LEN_W'(k) < out_rem_q) begin
        dout_o[8*k +: 8] = s_q[bit_pos(off_q + 8'(k)) +: 8];
      end
    end
  end

  assign din_ready_o  = (state_q == S_ABSORB);
  assign dout_valid_o = (state_q == S_SQUEEZE);
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign perm_run_o   = perm_run_q;
  assign perm_state_o = s_q;

endmodule
